// File: rtl/lh_pkg.sv
// Shared definitions for the light-hash digest hex serializer:
// ASCII constants, digest geometry, the FSM state type and the nibble-to-ASCII helper.
`timescale 1ns/1ps
package lh_pkg;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;
  localparam logic [7:0] NULL_CHAR     = 8'h00;

  localparam int DIGEST_W = 64;
  localparam int NIBBLES  = 16;
  localparam int CNT_W    = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } lh_ser_state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic uppercase);
    logic [7:0] base;
    base = uppercase ? ASCII_UPPER_A : ASCII_LOWER_A;
    if (nibble < 4'd10) return ASCII_ZERO + {4'h0, nibble};
    else                return base + {4'h0, nibble} - 8'd10;
  endfunction

endpackage

// File: rtl/lh_digest_hex_serializer_if.sv
// Byte stream carrying ASCII hex characters out of the serializer.
// Handshake: a character transfers on a rising clk edge where hex_valid && hex_ready;
// once hex_valid is high, hex_char/hex_valid/hex_last hold until that transfer happens.
`timescale 1ns/1ps
interface lh_digest_hex_serializer_if;
  logic [7:0] hex_char;
  logic       hex_valid;
  logic       hex_ready;
  logic       hex_last;

  modport master (output hex_char, output hex_valid, output hex_last, input  hex_ready);
  modport slave  (input  hex_char, input  hex_valid, input  hex_last, output hex_ready);
endinterface

// File: rtl/lh_digest_hex_serializer.sv
// Converts each 64-bit digest into 16 ASCII hex characters (MS nibble first), plus an
// optional newline, with a one-deep pending buffer and an overrun pulse on drops.
`timescale 1ns/1ps
module lh_digest_hex_serializer
  import lh_pkg::*;
#(
  parameter bit UPPERCASE      = 1'b1,
  parameter bit APPEND_NEWLINE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DIGEST_W-1:0]      digest_in,
  input  logic                     digest_valid,
  lh_digest_hex_serializer_if.master hex_o,
  output logic                     busy,
  output logic                     err_overrun,
  output lh_ser_state_t            dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = APPEND_NEWLINE ? CNT_W'(NIBBLES) : CNT_W'(NIBBLES - 1);

  lh_ser_state_t         state_q, state_d;
  logic [DIGEST_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DIGEST_W-1:0]   pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic [7:0]            hex_char_q, hex_char_d;
  logic                  hex_valid_q, hex_valid_d;
  logic                  hex_last_q, hex_last_d;
  logic                  err_q, err_d;

  logic accept;
  logic last_accept;

  assign accept      = hex_valid_q && hex_o.hex_ready;
  assign last_accept = accept && (count_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Pending is always empty here: it only fills while sending and drains on the last char.
        if (digest_valid) begin
          shift_d = digest_in;
          count_d = '0;
          state_d = ST_SEND;
        end
      end
      default: begin
        if (last_accept) begin
          if (pend_full_q) begin
            shift_d = pend_q;
            count_d = '0;
            if (digest_valid) pend_d = digest_in;
            else              pend_full_d = 1'b0;
          end else if (digest_valid) begin
            shift_d = digest_in;
            count_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (accept) begin
            shift_d = shift_q << 4;
            count_d = count_q + CNT_W'(1);
          end
          if (digest_valid) begin
            if (!pend_full_q) begin
              pend_d      = digest_in;
              pend_full_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
    endcase

    // Outputs are registered from the next-state values so the sink sees flop outputs.
    hex_valid_d = (state_d == ST_SEND);
    hex_last_d  = (state_d == ST_SEND) && (count_d == LAST_CNT);
    if (state_d != ST_SEND)                hex_char_d = NULL_CHAR;
    else if (count_d == CNT_W'(NIBBLES))   hex_char_d = ASCII_NEWLINE;
    else                                   hex_char_d = nibble_to_ascii(shift_d[DIGEST_W-1 -: 4], UPPERCASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      hex_char_q  <= NULL_CHAR;
      hex_valid_q <= 1'b0;
      hex_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      hex_char_q  <= hex_char_d;
      hex_valid_q <= hex_valid_d;
      hex_last_q  <= hex_last_d;
      err_q       <= err_d;
    end
  end

  assign hex_o.hex_char  = hex_char_q;
  assign hex_o.hex_valid = hex_valid_q;
  assign hex_o.hex_last  = hex_last_q;
  assign busy            = (state_q == ST_SEND) || pend_full_q;
  assign err_overrun     = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_lh_digest_hex_serializer.sv
// Scoreboard bench for the digest hex serializer: default build plus a lowercase,
// no-newline build, with expected characters queued at stimulus time.
`timescale 1ns/1ps
module tb_lh_digest_hex_serializer;
  import lh_pkg::*;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]   d_in, d2_in;
  logic          dv, dv2;
  logic          busy, busy2, err, err2;
  lh_ser_state_t st, st2;

  lh_digest_hex_serializer_if hx();
  lh_digest_hex_serializer_if hx2();

  lh_digest_hex_serializer #(.UPPERCASE(1'b1), .APPEND_NEWLINE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .digest_in(d_in), .digest_valid(dv),
    .hex_o(hx), .busy(busy), .err_overrun(err), .dbg_state(st)
  );

  lh_digest_hex_serializer #(.UPPERCASE(1'b0), .APPEND_NEWLINE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .digest_in(d2_in), .digest_valid(dv2),
    .hex_o(hx2), .busy(busy2), .err_overrun(err2), .dbg_state(st2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: {hex_last, hex_char}
  logic [8:0] exp_q[$];
  logic [8:0] exp2_q[$];

  task automatic push_digest(input logic [63:0] d, input bit upper, input bit nl, input bit second);
    string      s;
    logic [7:0] c;
    logic [8:0] e;
    s = $sformatf("%016h", d);
    for (int i = 0; i < 16; i++) begin
      c = s[i];
      if (upper && c >= 8'h61) c = c - 8'h20;
      e = {(!nl && i == 15), c};
      if (second) exp2_q.push_back(e);
      else        exp_q.push_back(e);
    end
    if (nl) begin
      if (second) exp2_q.push_back({1'b1, 8'h0A});
      else        exp_q.push_back({1'b1, 8'h0A});
    end
  endtask

  // monitors (sample on the falling edge)
  int   acc_cnt = 0;
  int   err_cnt = 0;
  int   hole_cnt = 0;
  bit   stall = 1'b0;
  logic [9:0] prev_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (err) err_cnt++;
      if (exp_q.size() != 0 && !(busy && hx.hex_valid)) hole_cnt++;
      if (stall)
        check("stall_hold", 64'({hx.hex_valid, hx.hex_last, hx.hex_char}), 64'(prev_out));
      if (hx.hex_valid && hx.hex_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) check("unexpected_char", 64'(hx.hex_valid), 64'd0);
        else                   check("char", 64'({hx.hex_last, hx.hex_char}), 64'(exp_q.pop_front()));
      end
      stall    = hx.hex_valid && !hx.hex_ready;
      prev_out = {hx.hex_valid, hx.hex_last, hx.hex_char};
    end
  end

  always @(negedge clk) begin
    if (rst_n && hx2.hex_valid && hx2.hex_ready) begin
      if (exp2_q.size() == 0) check("unexpected_char2", 64'(hx2.hex_valid), 64'd0);
      else                    check("char2", 64'({hx2.hex_last, hx2.hex_char}), 64'(exp2_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [63:0] d);
    d_in = d;
    dv   = 1'b1;
    tick();
    dv   = 1'b0;
  endtask

  task automatic drain(input bit rnd, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 600) begin
      hx.hex_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 600), 64'd1);
    check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, 64'(st), 64'(ST_IDLE));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char"},  64'(hx.hex_char),  64'h00);
    check({tag, "_valid"}, 64'(hx.hex_valid), 64'd0);
    check({tag, "_last"},  64'(hx.hex_last),  64'd0);
    check({tag, "_busy"},  64'(busy),         64'd0);
    check({tag, "_err"},   64'(err),          64'd0);
    check({tag, "_state"}, 64'(st),           64'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, h0, a0, n;
    d_in = '0; dv = 1'b0; d2_in = '0; dv2 = 1'b0;
    hx.hex_ready = 1'b0; hx2.hex_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_busy2", 64'(busy2), 64'd0);
    rst_n = 1'b1;
    tick();

    // basic: one digest, continuous ready, one-cycle latency
    hx.hex_ready = 1'b1;
    d_in = 64'h0123456789ABCDEF;
    dv   = 1'b1;
    push_digest(64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0);
    check("lat_pre_valid", 64'(hx.hex_valid), 64'd0);
    tick();
    dv = 1'b0;
    check("lat_post_valid", 64'(hx.hex_valid), 64'd1);
    check("lat_first_char", 64'(hx.hex_char), 64'h30);
    drain(1'b0, "basic");
    check("basic_valid_low", 64'(hx.hex_valid), 64'd0);

    // backpressure with random ready
    hx.hex_ready = 1'b0;
    push_digest(64'hDEADBEEF00C0FFEE, 1'b1, 1'b1, 1'b0);
    strobe(64'hDEADBEEF00C0FFEE);
    drain(1'b1, "bp");

    // back-to-back through the pending buffer
    hx.hex_ready = 1'b1;
    h0 = hole_cnt;
    a0 = acc_cnt;
    push_digest(64'h1111111111111111, 1'b1, 1'b1, 1'b0);
    strobe(64'h1111111111111111);
    repeat (4) tick();
    push_digest(64'h2222222222222222, 1'b1, 1'b1, 1'b0);
    strobe(64'h2222222222222222);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      check("pend_busy_during", 64'(busy), 64'd1);
      tick();
      n++;
    end
    check("pend_busy_after", 64'(busy), 64'd0);
    check("pend_accepts", 64'(acc_cnt - a0), 64'd34);
    check("pend_holes", 64'(hole_cnt - h0), 64'd1);
    drain(1'b0, "pend");

    // overrun: A, B, C on consecutive cycles with the sink stalled
    hx.hex_ready = 1'b0;
    e0 = err_cnt;
    push_digest(64'hA0A0A0A0A0A0A0A0, 1'b1, 1'b1, 1'b0);
    push_digest(64'hB1B1B1B1B1B1B1B1, 1'b1, 1'b1, 1'b0);
    strobe(64'hA0A0A0A0A0A0A0A0);
    strobe(64'hB1B1B1B1B1B1B1B1);
    strobe(64'hC2C2C2C2C2C2C2C2);
    repeat (3) tick();
    check("ovr_pulses", 64'(err_cnt - e0), 64'd1);
    check("ovr_busy", 64'(busy), 64'd1);
    drain(1'b0, "ovr");
    check("ovr_pulses_end", 64'(err_cnt - e0), 64'd1);

    // lowercase, no newline build
    push_digest(64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b1);
    d2_in = 64'hFEDCBA9876543210;
    dv2   = 1'b1;
    tick();
    dv2 = 1'b0;
    n = 0;
    while (exp2_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("p2_left", 64'(exp2_q.size()), 64'd0);
    check("p2_busy", 64'(busy2), 64'd0);
    check("p2_valid", 64'(hx2.hex_valid), 64'd0);

    // reset mid-stream with the pending buffer loaded
    hx.hex_ready = 1'b1;
    a0 = acc_cnt;
    push_digest(64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b1, 1'b0);
    strobe(64'hAAAAAAAAAAAAAAAA);
    strobe(64'h5555555555555555);
    n = 0;
    while (acc_cnt - a0 < 5 && n < 50) begin
      tick();
      n++;
    end
    check("mid_accepts", 64'(acc_cnt - a0), 64'd5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_valid", 64'(hx.hex_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    push_digest(64'h0, 1'b1, 1'b1, 1'b0);
    strobe(64'h0);
    drain(1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
